udp_stream: RTL and testbench

- UDP payload generator with an AXI4-Lite control slave and a 64-bit AXI4-Stream master.
- Emits fixed-length packets carrying a sequence-numbered, beat-indexed pattern. These feed the UDP/10G Ethernet offload path.
- Enabled out of reset, so it streams without any register writes.
- All logic runs on a single clock.

---
 rtl/udp_stream_if.sv | 60 ++++++
 rtl/udp_stream.sv | 277 +++++++++++++++++++++++++++
 tb/tb_udp_stream.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_stream_if.sv
// ---------------------------------------------------------------------------
// Bus interfaces used by udp_stream.
//   axil_if : AXI4-Lite control bus (aw/w/b/ar/r channels).
//             modport slave  - register block side
//             modport master - host/CPU side
//   axis_if : AXI4-Stream bus with tkeep, tuser (start of packet) and tlast.
//             modport master - packet source
//             modport slave  - packet sink
// ---------------------------------------------------------------------------
interface axil_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

interface axis_if #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8
);
    logic              tvalid;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tuser;
    logic              tlast;
    logic              tready;

    modport master (output tvalid, tdata, tkeep, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tuser, tlast, output tready);
endinterface

// File: rtl/udp_stream.sv
// ---------------------------------------------------------------------------
// udp_stream - fixed-length UDP payload pattern generator.
//
// Each beat carries {seq[31:0], 16'h0000, beat_index[15:0]}; tuser marks the
// first beat, tlast the final one, whose tkeep covers LAST_BYTES bytes.
// Streaming is enabled out of reset.
//
// Ports:
//   aclk      - sole clock, rising edge
//   aresetn   - asynchronous active-low reset
//   s00_axi   - AXI4-Lite register slave (8 word registers)
//   m00_axis  - 64-bit AXI4-Stream master
//
// Register map (word = addr[4:2]):
//   0 CTRL       bit0 enable, bit1 clear (self-clearing, reads 0)
//   1 PKT_BEATS  [15:0], 0 behaves as 1
//   2 GAP        [15:0], idle cycles between packets
//   3 PKT_COUNT  RO
//   4 BEAT_COUNT RO
//   5 LAST_BYTES [3:0], 0 or >8 behaves as 8
//   6 SEQ        RO
//   7 ID         RO 0x55445031
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | not streaming; starts a packet on the next edge if enabled
// ST_SEND  | presenting beats of the current packet (tvalid=1)
// ST_GAP   | inter-packet gap, gap_cnt down-counts to its terminal value 1
// ---------------------------------------------------------------------------
module udp_stream #(
    parameter int C_S00_AXI_DATA_WIDTH   = 32,
    parameter int C_S00_AXI_ADDR_WIDTH   = 5,
    parameter int C_M00_AXIS_TDATA_WIDTH = 64,
    parameter int C_M00_AXIS_TKEEP_WIDTH = 8
) (
    input  logic   aclk,
    input  logic   aresetn,
    axil_if.slave  s00_axi,
    axis_if.master m00_axis
);

    localparam logic [31:0] ID_VALUE = 32'h5544_5031;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

    state_t state, state_nxt;

    logic        ctrl_enable;
    logic [15:0] pkt_beats;
    logic [15:0] gap_cycles;
    logic [3:0]  last_bytes;
    logic [31:0] pkt_count;
    logic [31:0] beat_count;
    logic [31:0] seq;

    logic                            aw_rdy;
    logic                            bvalid_q;
    logic                            ar_rdy;
    logic                            rvalid_q;
    logic [C_S00_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [C_S00_AXI_DATA_WIDTH-1:0] rd_mux;
    logic                            wr_en;
    logic                            rd_en;
    logic                            clr_pulse;
    logic [2:0]                      wr_word;
    logic [2:0]                      rd_word;

    logic [15:0] beat_idx;
    logic [15:0] beats_l;
    logic [3:0]  lb_l;
    logic [15:0] gap_cnt;
    logic        is_last;
    logic        start_pkt;
    logic        beat_hs;
    logic        last_hs;
    logic        tvalid_w;
    logic [8:0]  keep_span;

    logic [C_M00_AXIS_TDATA_WIDTH-1:0] tdata_w;
    logic [C_M00_AXIS_TKEEP_WIDTH-1:0] tkeep_w;

    // ------------------------------------------------------------------
    // AXI4-Lite write channel: aw/w accepted together, one at a time
    // ------------------------------------------------------------------
    assign wr_word   = s00_axi.awaddr[C_S00_AXI_ADDR_WIDTH-1:2];
    assign wr_en     = aw_rdy && s00_axi.awvalid && s00_axi.wvalid;
    assign clr_pulse = wr_en && (wr_word == 3'd0) && s00_axi.wstrb[0] && s00_axi.wdata[1];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_rdy   <= 1'b0;
            bvalid_q <= 1'b0;
        end else begin
            // !aw_rdy keeps the ready to a single-cycle pulse
            aw_rdy <= s00_axi.awvalid && s00_axi.wvalid && !bvalid_q && !aw_rdy;
            if (wr_en)
                bvalid_q <= 1'b1;
            else if (s00_axi.bready)
                bvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ctrl_enable <= 1'b1;
            pkt_beats   <= 16'd8;
            gap_cycles  <= 16'd0;
            last_bytes  <= 4'd8;
        end else if (wr_en) begin
            case (wr_word)
                3'd0: if (s00_axi.wstrb[0]) ctrl_enable <= s00_axi.wdata[0];
                3'd1: begin
                    if (s00_axi.wstrb[0]) pkt_beats[7:0]  <= s00_axi.wdata[7:0];
                    if (s00_axi.wstrb[1]) pkt_beats[15:8] <= s00_axi.wdata[15:8];
                end
                3'd2: begin
                    if (s00_axi.wstrb[0]) gap_cycles[7:0]  <= s00_axi.wdata[7:0];
                    if (s00_axi.wstrb[1]) gap_cycles[15:8] <= s00_axi.wdata[15:8];
                end
                3'd5: if (s00_axi.wstrb[0]) last_bytes <= s00_axi.wdata[3:0];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // AXI4-Lite read channel
    // ------------------------------------------------------------------
    assign rd_word = s00_axi.araddr[C_S00_AXI_ADDR_WIDTH-1:2];
    assign rd_en   = ar_rdy && s00_axi.arvalid;

    always_comb begin
        rd_mux = '0;
        case (rd_word)
            3'd0:    rd_mux = {31'd0, ctrl_enable};
            3'd1:    rd_mux = {16'd0, pkt_beats};
            3'd2:    rd_mux = {16'd0, gap_cycles};
            3'd3:    rd_mux = pkt_count;
            3'd4:    rd_mux = beat_count;
            3'd5:    rd_mux = {28'd0, last_bytes};
            3'd6:    rd_mux = seq;
            default: rd_mux = ID_VALUE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_rdy   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ar_rdy <= s00_axi.arvalid && !rvalid_q && !ar_rdy;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (s00_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s00_axi.awready = aw_rdy;
    assign s00_axi.wready  = aw_rdy;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = 2'b00;
    assign s00_axi.arready = ar_rdy;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rdata   = rdata_q;
    assign s00_axi.rresp   = 2'b00;

    // ------------------------------------------------------------------
    // Stream FSM
    // ------------------------------------------------------------------
    assign tvalid_w = (state == ST_SEND);
    assign is_last  = (beat_idx == beats_l - 16'd1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_pkt = 1'b0;
        last_hs   = 1'b0;
        beat_hs   = tvalid_w && m00_axis.tready;
        case (state)
            ST_IDLE: begin
                if (ctrl_enable) begin
                    state_nxt = ST_SEND;
                    start_pkt = 1'b1;
                end
            end
            ST_SEND: begin
                if (beat_hs && is_last) begin
                    last_hs = 1'b1;
                    if (gap_cnt != 16'd0)
                        state_nxt = ST_GAP;
                    else if (ctrl_enable)
                        start_pkt = 1'b1;   // back-to-back, no bubble
                    else
                        state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                // The final gap cycle already does the idle decision, so the
                // line is quiet for exactly the latched number of cycles.
                if (gap_cnt == 16'd1) begin
                    if (ctrl_enable) begin
                        state_nxt = ST_SEND;
                        start_pkt = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // gap_cnt holds the latched GAP while sending and down-counts in ST_GAP.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_idx <= 16'd0;
            beats_l  <= 16'd0;
            lb_l     <= 4'd0;
            gap_cnt  <= 16'd0;
        end else if (start_pkt) begin
            beat_idx <= 16'd0;
            beats_l  <= (pkt_beats == 16'd0) ? 16'd1 : pkt_beats;
            lb_l     <= ((last_bytes == 4'd0) || (last_bytes > 4'd8)) ? 4'd8 : last_bytes;
            gap_cnt  <= gap_cycles;
        end else if (beat_hs) begin
            beat_idx <= beat_idx + 16'd1;
        end else if (state == ST_GAP) begin
            gap_cnt <= gap_cnt - 16'd1;
        end
    end

    // Clear takes priority over a coincident packet completion.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            seq        <= 32'd0;
            pkt_count  <= 32'd0;
            beat_count <= 32'd0;
        end else if (clr_pulse) begin
            seq        <= 32'd0;
            pkt_count  <= 32'd0;
            beat_count <= 32'd0;
        end else begin
            if (beat_hs)
                beat_count <= beat_count + 32'd1;
            if (last_hs) begin
                seq       <= seq + 32'd1;
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end

    // Outputs are gated by tvalid so everything reads 0 while idle.
    assign keep_span = (9'd1 << lb_l) - 9'd1;
    assign tdata_w   = tvalid_w ? {seq, 16'h0000, beat_idx} : '0;
    assign tkeep_w   = !tvalid_w ? '0 : (is_last ? keep_span[7:0] : 8'hFF);

    assign m00_axis.tvalid = tvalid_w;
    assign m00_axis.tdata  = tdata_w;
    assign m00_axis.tkeep  = tkeep_w;
    assign m00_axis.tuser  = tvalid_w && (beat_idx == 16'd0);
    assign m00_axis.tlast  = tvalid_w && is_last;

    logic unused_bits;
    assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0],
                           s00_axi.araddr[1:0], s00_axi.wdata[31:16], s00_axi.wstrb[3:2]};

endmodule

// File: tb/tb_udp_stream.sv
// ---------------------------------------------------------------------------
// Bench for udp_stream: a transaction-level reference model follows every
// accepted beat (seq, beat index, packet length, last-beat keep), the gap
// between packets, stall stability, and register readback.
// ---------------------------------------------------------------------------
module tb_udp_stream;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axil_if s00_axi ();
    axis_if m00_axis ();

    udp_stream dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s00_axi  (s00_axi),
        .m00_axis (m00_axis)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // raw values last written to the config registers
    int cfg_beats = 8;
    int cfg_lb    = 8;
    int cfg_gap   = 0;
    int clr_cnt   = 0;
    bit chk_gap   = 1'b0;

    function automatic logic [15:0] eff_beats(input int raw);
        return (raw == 0) ? 16'd1 : 16'(raw);
    endfunction

    function automatic int eff_lb(input int raw);
        return (raw == 0 || raw > 8) ? 8 : raw;
    endfunction

    function automatic logic [7:0] keep_of(input int n);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < n; i++) r[i] = 1'b1;
        return r;
    endfunction

    // ---------------- reference model / monitor ----------------
    logic [15:0] mk;
    logic [31:0] mseq, mpkts, mbeats;
    logic [15:0] pk_beats;
    int          pk_lb, pk_gap;
    int          clr_seen;
    bit          in_gap, gap_armed, last_tlast;
    int          gap_run, gap_exp;
    bit          prev_v, prev_r, prev_u, prev_l;
    logic [63:0] prev_d;
    logic [7:0]  prev_k;

    always @(negedge aclk) begin
        if (!aresetn) begin
            mk = 0; mseq = 0; mpkts = 0; mbeats = 0;
            pk_beats = 16'd8; pk_lb = 8; pk_gap = 0;
            prev_v = 0; prev_r = 0; in_gap = 0; gap_armed = 0;
            clr_seen = clr_cnt;
        end else begin
            if (clr_seen != clr_cnt) begin
                mseq = 0; mpkts = 0; mbeats = 0;
                clr_seen = clr_cnt;
            end
            if (prev_v && !prev_r) begin
                chk("stall_data", m00_axis.tdata, prev_d);
                chk("stall_ctl", {m00_axis.tvalid, m00_axis.tuser, m00_axis.tlast, m00_axis.tkeep},
                    {1'b1, prev_u, prev_l, prev_k});
            end
            if (m00_axis.tvalid) begin
                if (in_gap && gap_armed && chk_gap) chk("gap_len", gap_run, gap_exp);
                in_gap = 0;
            end else if (in_gap) begin
                gap_run++;
            end
            if (m00_axis.tvalid && m00_axis.tready) begin
                if (mk == 0) begin
                    pk_beats = eff_beats(cfg_beats);
                    pk_lb    = eff_lb(cfg_lb);
                    pk_gap   = cfg_gap;
                end
                chk("beat_data", m00_axis.tdata, {mseq, 16'h0000, mk});
                chk("beat_user", m00_axis.tuser, mk == 0);
                chk("beat_last", m00_axis.tlast, mk == pk_beats - 16'd1);
                chk("beat_keep", m00_axis.tkeep, (mk == pk_beats - 16'd1) ? keep_of(pk_lb) : 8'hFF);
                last_tlast = m00_axis.tlast;
                mbeats++;
                if (mk == pk_beats - 16'd1) begin
                    mk = 0; mseq++; mpkts++;
                    in_gap = 1; gap_run = 0; gap_exp = pk_gap; gap_armed = chk_gap;
                end else begin
                    mk++;
                end
            end
            prev_v = m00_axis.tvalid; prev_r = m00_axis.tready;
            prev_d = m00_axis.tdata;  prev_k = m00_axis.tkeep;
            prev_u = m00_axis.tuser;  prev_l = m00_axis.tlast;
        end
    end

    // ---------------- AXI4-Lite host tasks ----------------
    task automatic axil_write(input logic [4:0] a, input logic [31:0] d);
        bit seen = 0;
        @(posedge aclk); #1;
        s00_axi.awaddr = a; s00_axi.wdata = d; s00_axi.wstrb = 4'hF;
        s00_axi.awvalid = 1; s00_axi.wvalid = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (s00_axi.awready && s00_axi.wready) begin seen = 1; break; end
        end
        chk("aw_handshake", seen, 1);
        @(posedge aclk); #1;
        s00_axi.awvalid = 0; s00_axi.wvalid = 0; s00_axi.bready = 1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (s00_axi.bvalid) begin seen = 1; break; end
        end
        chk("b_valid", {seen, s00_axi.bresp}, {1'b1, 2'b00});
        @(posedge aclk); #1;
        s00_axi.bready = 0;
    endtask

    task automatic axil_read(input logic [4:0] a, output logic [31:0] d);
        bit seen = 0;
        d = '0;
        @(posedge aclk); #1;
        s00_axi.araddr = a; s00_axi.arvalid = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (s00_axi.arready) begin seen = 1; break; end
        end
        chk("ar_handshake", seen, 1);
        @(posedge aclk); #1;
        s00_axi.arvalid = 0; s00_axi.rready = 1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (s00_axi.rvalid) begin seen = 1; d = s00_axi.rdata; break; end
        end
        chk("r_valid", {seen, s00_axi.rresp}, {1'b1, 2'b00});
        @(posedge aclk); #1;
        s00_axi.rready = 0;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        axil_read(a, d);
        chk(tag, d, exp);
    endtask

    // disable with tready=1: current packet must end on tlast, then stay quiet
    task automatic stop_stream();
        bit idle = 0;
        int busy = 0;
        chk_gap = 0;
        axil_write(5'h00, 32'h0);
        for (int i = 0; i < 60; i++) begin
            @(negedge aclk);
            if (!m00_axis.tvalid) begin idle = 1; break; end
        end
        chk("stop_drain", idle, 1);
        chk("stop_tlast", last_tlast, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (m00_axis.tvalid) busy++;
        end
        chk("stop_idle", busy, 0);
    endtask

    logic [31:0] rd;
    bit          seen_v;

    initial begin
        m00_axis.tready = 0;
        s00_axi.awaddr = 0; s00_axi.awprot = 0; s00_axi.awvalid = 0;
        s00_axi.wdata = 0;  s00_axi.wstrb = 0;  s00_axi.wvalid = 0; s00_axi.bready = 0;
        s00_axi.araddr = 0; s00_axi.arprot = 0; s00_axi.arvalid = 0; s00_axi.rready = 0;

        // ---- reset state, first beat while stalled ----
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_outs", {m00_axis.tvalid, m00_axis.tuser, m00_axis.tlast, m00_axis.tkeep, m00_axis.tdata}, '0);
        chk("rst_axil", {s00_axi.awready, s00_axi.wready, s00_axi.bvalid, s00_axi.arready, s00_axi.rvalid}, '0);
        @(negedge aclk);
        aresetn = 1;
        seen_v = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            if (m00_axis.tvalid) begin seen_v = 1; break; end
        end
        chk("first_tvalid", seen_v, 1);
        chk("first_tdata", m00_axis.tdata, 64'h0);
        chk("first_tuser", m00_axis.tuser, 1);
        chk("first_tkeep", m00_axis.tkeep, 8'hFF);
        chk("first_tlast", m00_axis.tlast, 0);
        repeat (5) @(negedge aclk);

        // ---- defaults, tready held high ----
        @(posedge aclk); #1 m00_axis.tready = 1;
        repeat (4) @(posedge aclk);
        #1 chk_gap = 1;
        repeat (30) @(posedge aclk);
        stop_stream();
        read_chk("id_reg", 5'h1C, 32'h5544_5031);
        read_chk("ctrl_off", 5'h00, 32'h0);

        // ---- 3-beat packets, 5-byte tail, 4-cycle gap ----
        axil_write(5'h04, 32'd3); cfg_beats = 3;
        axil_write(5'h14, 32'd5); cfg_lb = 5;
        axil_write(5'h08, 32'd4); cfg_gap = 4;
        read_chk("beats_rb", 5'h04, 32'd3);
        @(posedge aclk); #1 m00_axis.tready = 0;
        axil_write(5'h00, 32'h3); clr_cnt++;
        read_chk("seq_clr", 5'h18, 32'd0);
        read_chk("beats_clr", 5'h10, 32'd0);
        @(posedge aclk); #1 m00_axis.tready = 1;
        repeat (3) @(posedge aclk);
        #1 chk_gap = 1;
        repeat (45) @(posedge aclk);
        #1 m00_axis.tready = 0;
        read_chk("pkt_count", 5'h0C, mpkts);
        read_chk("beat_count", 5'h10, mbeats);
        read_chk("seq_now", 5'h18, mseq);

        // ---- random backpressure, ten 8-beat packets ----
        @(posedge aclk); #1 m00_axis.tready = 1;
        stop_stream();
        axil_write(5'h04, 32'd8); cfg_beats = 8;
        axil_write(5'h14, 32'd0); cfg_lb = 0;
        axil_write(5'h08, 32'd1); cfg_gap = 1;
        @(posedge aclk); #1 m00_axis.tready = 0;
        axil_write(5'h00, 32'h3); clr_cnt++;
        @(posedge aclk); #1 chk_gap = 1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge aclk); #1;
            if (mbeats >= 80) break;
            m00_axis.tready = 1'($urandom_range(0, 1));
        end
        m00_axis.tready = 0;
        chk("rand_done", mbeats, 80);
        read_chk("beat_count80", 5'h10, 32'd80);
        read_chk("pkt_count10", 5'h0C, 32'd10);
        read_chk("seq10", 5'h18, 32'd10);

        // ---- PKT_BEATS=0 -> 1 beat, LAST_BYTES=9 -> 8 bytes ----
        @(posedge aclk); #1 m00_axis.tready = 1;
        stop_stream();
        axil_write(5'h04, 32'd0); cfg_beats = 0;
        axil_write(5'h14, 32'd9); cfg_lb = 9;
        axil_write(5'h08, 32'd0); cfg_gap = 0;
        axil_write(5'h00, 32'h1);
        repeat (3) @(posedge aclk);
        #1 chk_gap = 1;
        repeat (20) @(posedge aclk);

        // ---- reset in the middle of streaming ----
        seen_v = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (m00_axis.tvalid) begin seen_v = 1; break; end
        end
        chk("pre_rst_valid", seen_v, 1);
        @(posedge aclk); #1;
        chk_gap = 0;
        aresetn = 0;
        cfg_beats = 8; cfg_lb = 8; cfg_gap = 0;
        #1;
        chk("rst_drop", {m00_axis.tvalid, m00_axis.tlast, m00_axis.tuser}, 3'b000);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1;
        read_chk("id_after_rst", 5'h1C, 32'h5544_5031);
        read_chk("ctrl_after_rst", 5'h00, 32'h1);
        read_chk("beats_after_rst", 5'h04, 32'd8);
        repeat (10) @(posedge aclk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
